// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared types, default sizing constants and address qualification
//            helper for the multi-port register file.
// Contents : rf_state_t   - sweep-clear FSM state
//            RF_WIDTH     - default data width
//            RF_DEPTH     - default number of registers
//            RF_ZERO_REG  - default hardwired-zero register index
//            rf_addr_live - 1 when an address maps to a real, writable entry
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam int RF_WIDTH    = 64;
    localparam int RF_DEPTH    = 32;
    localparam int RF_ZERO_REG = 31;

    // An address is live when it falls inside the array and is not the
    // hardwired-zero index. A zero index equal to the depth never matches an
    // in-range address, which is how the zero register is switched off.
    function automatic logic rf_addr_live(
        input logic [31:0] addr,
        input logic [31:0] depth,
        input logic [31:0] zeroReg
    );
        return (addr < depth) && (addr != zeroReg);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_port
// Purpose  : One combinational read port. Forces zero during a sweep-clear,
//            for the zero register and for out-of-range addresses; otherwise
//            forwards same-cycle write data (when enabled) or the stored word.
// Ports    : i_inClear  - file is sweeping, all reads return zero
//            i_rdAddr   - read address
//            i_wrEn     - a qualified write is being performed this cycle
//            i_wrAddr   - address of that write
//            i_wrData   - data of that write
//            i_memFlat  - whole array, entry k at [k*WIDTH +: WIDTH]
//            o_rdData   - read data
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = RF_ZERO_REG,
    parameter int BYPASS   = 1
) (
    input  logic                   i_inClear,
    input  logic [ADDR_W-1:0]      i_rdAddr,
    input  logic                   i_wrEn,
    input  logic [ADDR_W-1:0]      i_wrAddr,
    input  logic [WIDTH-1:0]       i_wrData,
    input  logic [DEPTH*WIDTH-1:0] i_memFlat,
    output logic [WIDTH-1:0]       o_rdData
);

    localparam logic [31:0] c_DEPTH = 32'(DEPTH);
    localparam logic [31:0] c_ZERO  = 32'(ZERO_REG);
    localparam logic [31:0] c_WIDTH = 32'(WIDTH);

    logic        w_live;
    logic [31:0] w_base;

    assign w_live = rf_addr_live(32'(i_rdAddr), c_DEPTH, c_ZERO);
    // Only used when w_live holds, so the slice always lies inside the array.
    assign w_base = 32'(i_rdAddr) * c_WIDTH;

    always_comb begin
        o_rdData = '0;
        if (!i_inClear && w_live) begin
            // i_wrEn is already qualified, so a matching write address is live.
            if ((BYPASS != 0) && i_wrEn && (i_wrAddr == i_rdAddr)) begin
                o_rdData = i_wrData;
            end else begin
                o_rdData = i_memFlat[w_base +: WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : regfile_multiport
// Purpose  : Parametrised register file with NUM_RD combinational read ports,
//            one write port, a hardwired zero register, optional write-to-read
//            bypass and a sequential sweep-clear engine that zeroes every
//            entry after reset or on request.
// Ports    : clk    - clock, all state updates on the rising edge
//            reset  - synchronous active-high reset, restarts the sweep
//            clear  - request a full sweep-clear
//            ready  - sweep finished, writes accepted
//            write  - write enable
//            wrAddr - write address
//            wrData - write data
//            rdAddr - packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//            rdData - packed read data, port i at [i*WIDTH +: WIDTH]
// Revision : 1.0 - initial release
// ============================================================================
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = RF_WIDTH,
    parameter  int DEPTH    = RF_DEPTH,
    parameter  int NUM_RD   = 2,
    parameter  int ZERO_REG = RF_ZERO_REG,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    output logic                     ready,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    output logic [NUM_RD*WIDTH-1:0]  rdData
);

    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [31:0]       c_DEPTH = 32'(DEPTH);
    localparam logic [31:0]       c_ZERO  = 32'(ZERO_REG);

    rf_state_t              r_state;
    rf_state_t              w_stateNext;
    logic [ADDR_W-1:0]      r_cnt;
    logic [ADDR_W-1:0]      w_cntNext;
    logic                   r_ready;
    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [DEPTH*WIDTH-1:0] w_memFlat;
    logic                   w_inClear;
    logic                   w_sweepWr;
    logic                   w_wrEn;

    assign w_inClear = (r_state == RF_CLEAR);

    // A clear request restarts the sweep, so that edge writes nothing.
    assign w_sweepWr = w_inClear && !clear;

    // A write coinciding with a clear request in READY still lands; the
    // following sweep overwrites it.
    assign w_wrEn = (r_state == RF_READY) && write
                  && rf_addr_live(32'(wrAddr), c_DEPTH, c_ZERO);

    // ------------------------------------------------------------------
    // Sweep-clear FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            RF_CLEAR: begin
                if (clear) begin
                    w_cntNext = '0;
                end else if (r_cnt == c_LAST) begin
                    w_stateNext = RF_READY;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + ADDR_W'(1);
                end
            end
            RF_READY: begin
                if (clear) begin
                    w_stateNext = RF_CLEAR;
                    w_cntNext   = '0;
                end
            end
            default: begin
                w_stateNext = RF_CLEAR;
                w_cntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RF_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_ready <= (w_stateNext == RF_READY);
        end
    end

    assign ready = r_ready;

    // ------------------------------------------------------------------
    // Storage: the sweep and the write port are mutually exclusive by state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_sweepWr) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wrEn) begin
                r_mem[wrAddr] <= wrData;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign w_memFlat[g*WIDTH +: WIDTH] = r_mem[g];
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rdPort
        regfile_read_port #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rdPort (
            .i_inClear (w_inClear),
            .i_rdAddr  (rdAddr[p*ADDR_W +: ADDR_W]),
            .i_wrEn    (w_wrEn),
            .i_wrAddr  (wrAddr),
            .i_wrData  (wrData),
            .i_memFlat (w_memFlat),
            .o_rdData  (rdData[p*WIDTH +: WIDTH])
        );
    end

endmodule
`default_nettype wire
